// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/execute/memory/writeback control for the RV32 datapath,
// gating pc/rf/ir writes, with handshake timeout, ebreak halt and retired-instruction count.
module exec_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             ifu_req,
  input  logic             ifu_ready,
  input  logic             ifu_rvalid,
  output logic             ir_wen,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             en_Wreg_in,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_ready,
  input  logic             lsu_rvalid,
  output logic             wb_sel_mem,
  output logic             pc_wen,
  output logic             rf_wen,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instret
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [3:0] {
    IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR
  } state_t;
  state_t state, nxt;
  logic [TW-1:0] tcnt;
  logic expire, retire, count;
  assign expire = tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    nxt        = state;
    ifu_req    = 1'b0;
    ir_wen     = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    wb_sel_mem = 1'b0;
    pc_wen     = 1'b0;
    rf_wen     = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    retire     = 1'b0;
    count      = 1'b0;
    case (state)
      IDLE: nxt = run ? FETCH_REQ : IDLE;
      FETCH_REQ: begin
        ifu_req = 1'b1;
        nxt     = ifu_ready ? FETCH_WAIT : expire ? ERR : FETCH_REQ;
      end
      FETCH_WAIT: begin
        ir_wen = ifu_rvalid;
        nxt    = ifu_rvalid ? EXEC : expire ? ERR : FETCH_WAIT;
      end
      EXEC:
        if (is_load && is_store) nxt = ERR;
        else if (is_ebreak) begin
          count = 1'b1;
          nxt   = HALT;
        end else if (is_load || is_store) nxt = MEM_REQ;
        else retire = 1'b1;
      MEM_REQ: begin
        lsu_req = 1'b1;
        lsu_we  = is_store;
        nxt     = lsu_ready ? MEM_WAIT : expire ? ERR : MEM_REQ;
      end
      MEM_WAIT:
        if (lsu_rvalid) begin
          retire = is_store;
          nxt    = is_store ? state : WB;
        end else if (expire) nxt = ERR;
      WB: begin
        wb_sel_mem = 1'b1;
        retire     = 1'b1;
      end
      HALT: halted = 1'b1;
      ERR: err = 1'b1;
      default: nxt = ERR;
    endcase
    // a store acknowledge retires without a register write
    if (retire) begin
      pc_wen = 1'b1;
      rf_wen = en_Wreg_in && state != MEM_WAIT;
      count  = 1'b1;
      nxt    = run ? FETCH_REQ : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      instret <= '0;
    end else begin
      state   <= nxt;
      tcnt    <= nxt != state ? '0
               : state inside {FETCH_REQ, FETCH_WAIT, MEM_REQ, MEM_WAIT} ? tcnt + 1'b1 : tcnt;
      if (count) instret <= instret + 1'b1;
    end
  end
endmodule
